// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared constants for the decode-stage scoreboard: PC register index, GPR count,
// RegSrc bit positions and the in-flight counter width helper.
package decode_hazard_ctrl_pkg;

  localparam logic [3:0] REG_PC  = 4'hF;
  localparam int         NUM_GPR = 15;

  // RegSrc control bits: [0] forces RA1 to the PC, [1] steers RA2 to Rd (store data)
  localparam int RS_RA1_PC = 0;
  localparam int RS_RA2_RD = 1;

  function automatic int cnt_width(input int max_n);
    return $clog2(max_n + 1);
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode/write-back handshake bundle between the control unit and the hazard controller.
interface decode_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   dec_valid;
  logic [3:0]             dec_rn;
  logic [3:0]             dec_rm;
  logic [3:0]             dec_rd;
  logic [1:0]             reg_src;
  logic                   uses_ra1;
  logic                   uses_ra2;
  logic                   dec_wr;
  logic                   wb_valid;
  logic [3:0]             wb_rd;
  logic                   flush;
  logic [3:0]             ra1;
  logic [3:0]             ra2;
  logic                   stall_d;
  logic                   issue;
  logic [14:0]            busy_vec;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   err_underflow;

  modport master (
    output dec_valid, dec_rn, dec_rm, dec_rd, reg_src, uses_ra1, uses_ra2, dec_wr,
           wb_valid, wb_rd, flush,
    input  ra1, ra2, stall_d, issue, busy_vec, stall_count, err_underflow
  );

  modport slave (
    input  dec_valid, dec_rn, dec_rm, dec_rd, reg_src, uses_ra1, uses_ra2, dec_wr,
           wb_valid, wb_rd, flush,
    output ra1, ra2, stall_d, issue, busy_vec, stall_count, err_underflow
  );
endinterface

// File: rtl/decode_hazard_ctrl_counter.sv
// Per-register in-flight write counter: +1 on issue, -1 on write-back, saturating at MAX.
module hazard_counter #(
  parameter int MAX   = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);
  logic [CNT_W-1:0] r_cnt;

  // simultaneous issue and write-back cancel; a lone write-back on an idle register is an error
  assign o_underflow = i_dec && !i_inc && (r_cnt == '0);
  assign o_cnt       = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != CNT_W'(MAX)) r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scoreboard: resolves regfile read addresses, detects RAW/WAW hazards against
// in-flight writes to R0..R14 and stalls fetch/decode; R15 reads return PC+8 and never hazard.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int WB_BYPASS    = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_hazard_ctrl_if.slave  bus
);
  localparam int CNT_W = cnt_width(MAX_INFLIGHT);

  logic [3:0]                  w_ra1;
  logic [3:0]                  w_ra2;
  logic [15:0][CNT_W-1:0]      w_cnt_ext;
  logic [NUM_GPR-1:0]          w_inc;
  logic [NUM_GPR-1:0]          w_dec;
  logic [NUM_GPR-1:0]          w_uf;
  logic [NUM_GPR-1:0]          w_busy;
  logic                        w_clr1;
  logic                        w_clr2;
  logic                        w_raw;
  logic                        w_waw;
  logic                        w_live;
  logic                        w_stall;
  logic                        w_issue;
  logic [STALL_CNT_W-1:0]      r_stall_cnt;
  logic                        r_err;

  assign w_ra1 = bus.reg_src[RS_RA1_PC] ? REG_PC     : bus.dec_rn;
  assign w_ra2 = bus.reg_src[RS_RA2_RD] ? bus.dec_rd : bus.dec_rm;

  // slot 15 is a constant-zero counter so R15 lookups never see a pending write
  assign w_cnt_ext[15] = '0;

  // a write-back retiring the last pending write is visible through the regfile this cycle
  assign w_clr1 = bus.wb_valid && (bus.wb_rd == w_ra1) && (WB_BYPASS != 0) &&
                  (w_cnt_ext[w_ra1] == CNT_W'(1));
  assign w_clr2 = bus.wb_valid && (bus.wb_rd == w_ra2) && (WB_BYPASS != 0) &&
                  (w_cnt_ext[w_ra2] == CNT_W'(1));

  assign w_raw = (bus.uses_ra1 && (w_ra1 != REG_PC) && (w_cnt_ext[w_ra1] != '0) && !w_clr1) ||
                 (bus.uses_ra2 && (w_ra2 != REG_PC) && (w_cnt_ext[w_ra2] != '0) && !w_clr2);
  assign w_waw = bus.dec_wr && (bus.dec_rd != REG_PC) &&
                 (w_cnt_ext[bus.dec_rd] == CNT_W'(MAX_INFLIGHT));

  assign w_live  = bus.dec_valid && !bus.flush;
  assign w_stall = w_live && (w_raw || w_waw);
  assign w_issue = w_live && !w_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GPR; gi++) begin : g_reg
      assign w_inc[gi]  = w_issue && bus.dec_wr && (bus.dec_rd == 4'(gi));
      assign w_dec[gi]  = bus.wb_valid && (bus.wb_rd == 4'(gi));
      assign w_busy[gi] = (w_cnt_ext[gi] != '0);

      hazard_counter #(
        .MAX   (MAX_INFLIGHT),
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_inc[gi]),
        .i_dec       (w_dec[gi]),
        .o_cnt       (w_cnt_ext[gi]),
        .o_underflow (w_uf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (|w_uf) r_err <= 1'b1;
    end
  end

  assign bus.ra1           = w_ra1;
  assign bus.ra2           = w_ra2;
  assign bus.stall_d       = w_stall;
  assign bus.issue         = w_issue;
  assign bus.busy_vec      = w_busy;
  assign bus.stall_count   = r_stall_cnt;
  assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: hand-computed expectations for reset, RAW/WAW,
// RegSrc muxing, flush priority, underflow and stall-counter saturation.
module tb_decode_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  decode_hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();

  decode_hazard_ctrl #(
    .MAX_INFLIGHT (3),
    .WB_BYPASS    (1),
    .STALL_CNT_W  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid = 1'b0; bus.dec_rn = 4'd0; bus.dec_rm = 4'd0; bus.dec_rd = 4'd0;
    bus.reg_src = 2'b00; bus.uses_ra1 = 1'b0; bus.uses_ra2 = 1'b0; bus.dec_wr = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = 4'd0; bus.flush = 1'b0;
  endtask

  task automatic dec(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                     input logic [1:0] rs, input logic u1, input logic u2, input logic wr);
    bus.dec_valid = 1'b1; bus.dec_rn = rn; bus.dec_rm = rm; bus.dec_rd = rd;
    bus.reg_src = rs; bus.uses_ra1 = u1; bus.uses_ra2 = u2; bus.dec_wr = wr;
  endtask

  task automatic wb(input logic v, input logic [3:0] rd);
    bus.wb_valid = v; bus.wb_rd = rd;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_busy", 32'(bus.busy_vec), 32'h0);
    chk("rst_stall_cnt", 32'(bus.stall_count), 32'h0);
    chk("rst_err", 32'(bus.err_underflow), 32'h0);
    rst_n = 1'b1;
    tick();

    // three issues, one stalled cycle, then asynchronous reset mid-cycle
    dec(0, 0, 1, 2'b00, 0, 0, 1); tick();
    dec(0, 0, 2, 2'b00, 0, 0, 1); tick();
    dec(0, 0, 3, 2'b00, 0, 0, 1); tick();
    dec(1, 0, 0, 2'b00, 1, 0, 0); #1;
    chk("t1_stall", 32'(bus.stall_d), 32'h1);
    tick();
    chk("t1_busy", 32'(bus.busy_vec), 32'h000E);
    chk("t1_stall_cnt", 32'(bus.stall_count), 32'h1);
    idle();
    rst_n = 1'b0; #1;
    chk("t1_arst_busy", 32'(bus.busy_vec), 32'h0);
    chk("t1_arst_stall_cnt", 32'(bus.stall_count), 32'h0);
    chk("t1_arst_err", 32'(bus.err_underflow), 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // RAW on R3 with write-back bypass
    dec(0, 0, 3, 2'b00, 0, 0, 1); #1;
    chk("t2_issue_add", 32'(bus.issue), 32'h1);
    tick();
    chk("t2_busy3", 32'(bus.busy_vec), 32'h0008);
    dec(3, 0, 0, 2'b00, 1, 0, 0); #1;
    chk("t2_raw_stall", 32'(bus.stall_d), 32'h1);
    chk("t2_raw_noissue", 32'(bus.issue), 32'h0);
    tick();
    wb(1, 3); #1;
    chk("t2_bypass_stall", 32'(bus.stall_d), 32'h0);
    chk("t2_bypass_issue", 32'(bus.issue), 32'h1);
    tick();
    idle(); #1;
    chk("t2_cnt3_zero", 32'(bus.busy_vec), 32'h0);
    chk("t2_stall_cnt", 32'(bus.stall_count), 32'h1);

    // RegSrc muxing
    dec(0, 0, 2, 2'b00, 0, 0, 1); tick();
    dec(5, 6, 2, 2'b11, 1, 1, 0); #1;
    chk("t3_ra1", 32'(bus.ra1), 32'hF);
    chk("t3_ra2", 32'(bus.ra2), 32'h2);
    chk("t3_stall_rd", 32'(bus.stall_d), 32'h1);
    idle(); wb(1, 2); tick();
    wb(0, 0);
    dec(0, 0, 5, 2'b00, 0, 0, 1); tick();
    dec(0, 0, 6, 2'b00, 0, 0, 1); tick();
    dec(5, 6, 2, 2'b11, 1, 1, 0); #1;
    chk("t3_busy56", 32'(bus.busy_vec), 32'h0060);
    chk("t3_nostall_pc_rd", 32'(bus.stall_d), 32'h0);
    dec(5, 6, 2, 2'b00, 1, 1, 0); #1;
    chk("t3_stall_rn_rm", 32'(bus.stall_d), 32'h1);
    idle(); wb(1, 5); tick();
    wb(1, 6); tick();
    idle(); #1;
    chk("t3_drained", 32'(bus.busy_vec), 32'h0);

    // WAW limit on R4 and simultaneous issue + write-back
    dec(0, 0, 4, 2'b00, 0, 0, 1); tick();
    dec(0, 0, 4, 2'b00, 0, 0, 1); tick();
    wb(1, 4); #1;
    chk("t4_simul_issue", 32'(bus.issue), 32'h1);
    tick();
    wb(0, 0); #1;
    chk("t4_cnt2_nowaw", 32'(bus.stall_d), 32'h0);
    tick();
    #1;
    chk("t4_cnt3_waw", 32'(bus.stall_d), 32'h1);
    wb(1, 4); #1;
    chk("t4_waw_ignores_wb", 32'(bus.stall_d), 32'h1);
    idle(); wb(1, 4); tick();
    tick();
    chk("t4_busy4", 32'(bus.busy_vec), 32'h0010);
    tick();
    wb(0, 0); #1;
    chk("t4_drained", 32'(bus.busy_vec), 32'h0);
    chk("t4_no_err", 32'(bus.err_underflow), 32'h0);
    chk("t4_stall_cnt", 32'(bus.stall_count), 32'h1);

    // flush priority
    dec(0, 0, 8, 2'b00, 0, 0, 1); bus.flush = 1'b1; #1;
    chk("t5_flush_noissue", 32'(bus.issue), 32'h0);
    chk("t5_flush_nostall", 32'(bus.stall_d), 32'h0);
    tick();
    idle(); #1;
    chk("t5_flush_busy", 32'(bus.busy_vec), 32'h0);
    chk("t5_flush_stall_cnt", 32'(bus.stall_count), 32'h1);

    // R15 write-back ignored, then underflow
    wb(1, 15); tick();
    chk("t6_wb_pc_noerr", 32'(bus.err_underflow), 32'h0);
    wb(1, 7); tick();
    chk("t6_underflow", 32'(bus.err_underflow), 32'h1);
    wb(0, 0); tick();
    chk("t6_sticky", 32'(bus.err_underflow), 32'h1);

    // stall counter saturation
    dec(0, 0, 9, 2'b00, 0, 0, 1); tick();
    dec(9, 0, 0, 2'b00, 1, 0, 0); #1;
    chk("t6_hold_stall", 32'(bus.stall_d), 32'h1);
    repeat (70000) @(posedge clk);
    #1;
    chk("t6_stall_sat", 32'(bus.stall_count), 32'hFFFF);
    bus.dec_valid = 1'b0; #1;
    chk("t6_novalid_stall", 32'(bus.stall_d), 32'h0);
    chk("t6_novalid_issue", 32'(bus.issue), 32'h0);
    chk("t6_sticky_end", 32'(bus.err_underflow), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
